// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
//   owner_e   : identifies which port owns a memory access (m0 = core, m1 = loader/debug).
//   mem_req_t : one request bundle as presented by either port.
//   DEF_*     : default address/data widths and m1 lock budget.
package dmem_arb_pkg;

    localparam int DEF_AW       = 11;
    localparam int DEF_DW       = 32;
    localparam int DEF_MAX_HOLD = 8;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    typedef struct packed {
        logic              we;
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker with a bounded lock for requester 1.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   i_req[1:0]  : request per port (bit 0 = m0, bit 1 = m1)
//   i_lock      : m1 asks to keep the grant across consecutive cycles
//   o_gnt[1:0]  : one-hot grant, combinational from i_req and state; 0 during reset
module arb_rr2
    import dmem_arb_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_lock,
    output logic [1:0] o_gnt
);

    owner_e     r_last;     // port granted most recently (any past cycle)
    logic       r_m1_prev;  // m1 was granted in the immediately preceding cycle
    logic [7:0] r_hold;     // consecutive m1 grants taken while m0 was waiting
    logic       w_lock;

    always_comb begin
        o_gnt  = 2'b00;
        // The lock only extends a grant m1 already holds; it never steals one.
        w_lock = r_m1_prev & i_lock & i_req[1] & (r_hold < 8'(MAX_HOLD));
        if (!reset) begin
            if (i_req == 2'b11) begin
                o_gnt = (w_lock || r_last == OWN_M0) ? 2'b10 : 2'b01;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last    <= OWN_M1;  // m0 wins the first tie
            r_m1_prev <= 1'b0;
            r_hold    <= 8'd0;
        end else begin
            if (o_gnt != 2'b00) begin
                r_last <= o_gnt[1] ? OWN_M1 : OWN_M0;
            end
            r_m1_prev <= o_gnt[1];
            // Budget is only consumed while m0 is actually being kept waiting.
            if (o_gnt[0] || !i_req[0]) begin
                r_hold <= 8'd0;
            end else if (o_gnt[1]) begin
                r_hold <= r_hold + 8'd1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous-read data memory between the core
// load/store port (m0) and a loader/debug port (m1).
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   mX_req/we/addr/wdata       : request bundle per port, held until granted
//   m1_lock                    : m1 requests back-to-back ownership (bounded by MAX_HOLD)
//   mX_gnt                     : same-cycle acceptance
//   mX_rvalid/rdata            : read return, one cycle after a read grant
//   mem_ce/we/addr/wdata/rdata : memory-side interface
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic [1:0] w_gnt;
    logic       r_tag_valid;
    owner_e     r_tag_owner;

    arb_rr2 #(
        .MAX_HOLD(MAX_HOLD)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .i_req ({m1_req, m0_req}),
        .i_lock(m1_lock),
        .o_gnt (w_gnt)
    );

    assign m0_gnt = w_gnt[0];
    assign m1_gnt = w_gnt[1];

    // m0 values drive the memory bus whenever m1 is not granted, idle included.
    assign mem_ce    = w_gnt[0] | w_gnt[1];
    assign mem_we    = w_gnt[1] ? m1_we : (w_gnt[0] & m0_we);
    assign mem_addr  = w_gnt[1] ? m1_addr : m0_addr;
    assign mem_wdata = w_gnt[1] ? m1_wdata : m0_wdata;

    // Owner tag follows the memory's one-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag_valid <= 1'b0;
            r_tag_owner <= OWN_M0;
        end else begin
            r_tag_valid <= mem_ce & ~mem_we;
            r_tag_owner <= w_gnt[1] ? OWN_M1 : OWN_M0;
        end
    end

    assign m0_rvalid = r_tag_valid & (r_tag_owner == OWN_M0);
    assign m1_rvalid = r_tag_valid & (r_tag_owner == OWN_M1);
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Valid/ready contract: a port raises mX_req with its bundle and holds it
// until mX_gnt is seen high in the same cycle; a read answers with mX_rvalid
// exactly one cycle after its grant, a write never answers.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW       = 11;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_ce, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- check helpers ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        failures++;
        $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    // ---------------- memory instance stand-in ----------------
    logic [DW-1:0] ram [0:2047];
    bit            ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 2048; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else if (mem_ce) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // ---------------- reference model + scoreboard push ----------------
    logic [DW-1:0] exp_q0[$], exp_q1[$];
    int            due_q0[$], due_q1[$];
    int            cyc = 0;

    logic [DW-1:0] ref_mem [0:2047];
    bit            ref_ready = 1'b0;
    int            m_last = 1;     // port granted most recently
    int            m_hold = 0;     // m1 grants taken while m0 waited
    bit            m_m1_prev = 1'b0;

    always @(negedge clk) begin
        int            winner;
        bit            locked;
        logic [1:0]    exp_gnt;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        if (!ref_ready) begin
            for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
            ref_ready = 1'b1;
        end
        if (reset) begin
            check("gnt_in_reset", {30'b0, m1_gnt, m0_gnt}, 32'd0);
            m_last = 1;
            m_hold = 0;
            m_m1_prev = 1'b0;
        end else begin
            if (m0_req && m1_req) begin
                locked = m_m1_prev && m1_lock && (m_hold < MAX_HOLD);
                winner = locked ? 1 : 1 - m_last;
            end else if (m0_req) winner = 0;
            else if (m1_req)     winner = 1;
            else                 winner = -1;
            exp_gnt = (winner == 0) ? 2'b01 : (winner == 1) ? 2'b10 : 2'b00;
            check("gnt", {30'b0, m1_gnt, m0_gnt}, {30'b0, exp_gnt});
            check("mem_ce", 32'(mem_ce), 32'(winner >= 0));
            if (winner >= 0) begin
                we    = (winner == 1) ? m1_we : m0_we;
                addr  = (winner == 1) ? m1_addr : m0_addr;
                wdata = (winner == 1) ? m1_wdata : m0_wdata;
                check("mem_we", 32'(mem_we), 32'(we));
                check("mem_addr", 32'(mem_addr), 32'(addr));
                if (we) begin
                    check("mem_wdata", mem_wdata, wdata);
                    ref_mem[addr] = wdata;
                end else if (winner == 0) begin
                    exp_q0.push_back(ref_mem[addr]);
                    due_q0.push_back(cyc + 1);
                end else begin
                    exp_q1.push_back(ref_mem[addr]);
                    due_q1.push_back(cyc + 1);
                end
                m_last = winner;
            end
            if (!m0_req || winner == 0) m_hold = 0;
            else if (winner == 1)       m_hold = m_hold + 1;
            m_m1_prev = (winner == 1);
        end
    end

    // ---------------- monitor: pop and compare read returns ----------------
    always @(posedge clk) begin
        #2;
        cyc++;
        if (reset) begin
            check("rvalid_in_reset", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
            exp_q0.delete(); due_q0.delete();
            exp_q1.delete(); due_q1.delete();
        end else begin
            if (m0_rvalid) begin
                if (due_q0.size() == 0 || due_q0[0] != cyc) begin
                    fail_now("m0_rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    check("m0_rdata", m0_rdata, exp_q0[0]);
                    void'(exp_q0.pop_front());
                    void'(due_q0.pop_front());
                end
            end else if (due_q0.size() != 0 && due_q0[0] <= cyc) begin
                fail_now("m0_rvalid_missing", 32'd0, 32'd1);
                void'(exp_q0.pop_front());
                void'(due_q0.pop_front());
            end
            if (m1_rvalid) begin
                if (due_q1.size() == 0 || due_q1[0] != cyc) begin
                    fail_now("m1_rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    check("m1_rdata", m1_rdata, exp_q1[0]);
                    void'(exp_q1.pop_front());
                    void'(due_q1.pop_front());
                end
            end else if (due_q1.size() != 0 && due_q1[0] <= cyc) begin
                fail_now("m1_rvalid_missing", 32'd0, 32'd1);
                void'(exp_q1.pop_front());
                void'(due_q1.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1;
        reset   = 1'b1;
        m0_req  = 1'b0;
        m1_req  = 1'b0;
        m1_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic new_req(input int port);
        mem_req_t r;
        bit       go;
        go      = ($urandom_range(0, 3) != 0);
        r.we    = 1'($urandom_range(0, 1));
        r.addr  = 11'($urandom_range(0, 15));
        r.wdata = $urandom;
        if (port == 0) begin
            m0_req = go; m0_we = r.we; m0_addr = r.addr; m0_wdata = r.wdata;
        end else begin
            m1_req = go; m1_we = r.we; m1_addr = r.addr; m1_wdata = r.wdata;
        end
    endtask

    task automatic run_random(input int n, input bit lock_en);
        logic g0, g1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            g0 = m0_gnt;
            g1 = m1_gnt;
            @(posedge clk);
            #1;
            if (!m0_req || g0) new_req(0);
            if (!m1_req || g1) new_req(1);
            m1_lock = lock_en && ($urandom_range(0, 3) != 0);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int         we_cnt;
        logic       rv_seen;
        logic [1:0] exp_pair;

        do_reset();

        // m0 reads addr 3 alone
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'd3;
        sample();
        check("t1_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd1);
        tick();
        m0_req = 1'b0;
        sample();
        check("t1_m0_rvalid", 32'(m0_rvalid), 32'd1);
        check("t1_m0_rdata", m0_rdata, 32'hA5A5_0003);
        check("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);

        // both read continuously after reset: alternate starting with m0
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'd1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'd2;
        for (int i = 0; i < 4; i++) begin
            sample();
            exp_pair = (i % 2 == 0) ? 2'b01 : 2'b10;
            check("t2_alternate", {30'b0, m1_gnt, m0_gnt}, {30'b0, exp_pair});
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0;

        // locked m1 write burst against a waiting m0, then readback
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'd0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 11'd7; m1_wdata = 32'h1234_5678; m1_lock = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample();
            exp_pair = (i % 4 == 0) ? 2'b01 : 2'b10;
            check("t3_lock_seq", {30'b0, m1_gnt, m0_gnt}, {30'b0, exp_pair});
            tick();
        end
        m1_req = 1'b0; m1_lock = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'd7;
        sample();
        check("t3_rb_gnt", 32'(m0_gnt), 32'd1);
        tick();
        m0_req = 1'b0;
        sample();
        check("t3_rb_rvalid", 32'(m0_rvalid), 32'd1);
        check("t3_rb_rdata", m0_rdata, 32'h1234_5678);

        // m1 drops lock after one locked grant
        do_reset();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'd5; m1_lock = 1'b1;
        sample();
        check("t5_m1_alone", 32'(m1_gnt), 32'd1);
        tick();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'd6;
        sample();
        check("t5_m1_locked", {30'b0, m1_gnt, m0_gnt}, 32'd2);
        tick();
        m1_lock = 1'b0;
        sample();
        check("t5_m0_after_drop", {30'b0, m1_gnt, m0_gnt}, 32'd1);
        tick();
        m0_req = 1'b0; m1_req = 1'b0;

        // reset right after an m1 read grant
        do_reset();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'd9;
        sample();
        check("t4_m1_gnt", 32'(m1_gnt), 32'd1);
        #1;
        reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'd1; m1_addr = 11'd2;
        @(posedge clk);
        #2;
        check("t4_m1_rvalid_dropped", 32'(m1_rvalid), 32'd0);
        sample();
        check("t4_gnt_in_reset", {30'b0, m1_gnt, m0_gnt}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sample();
        check("t4_first_tie_m0", {30'b0, m1_gnt, m0_gnt}, 32'd1);
        check("t4_no_rvalid_after", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        tick();
        m0_req = 1'b0; m1_req = 1'b0;

        // single m0 write: one mem_we cycle, no rvalid
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 11'd20; m0_wdata = $urandom;
        we_cnt = 0;
        rv_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            if (mem_we) we_cnt++;
            rv_seen = rv_seen | m0_rvalid | m1_rvalid;
            tick();
            m0_req = 1'b0;
        end
        check("t6_we_cycles", 32'(we_cnt), 32'd1);
        check("t6_no_rvalid", 32'(rv_seen), 32'd0);

        // randomized traffic, without then with lock requests
        do_reset();
        run_random(2000, 1'b0);
        run_random(2000, 1'b1);
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
        repeat (4) tick();
        check("queues_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
